// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe pixel feeder: input FSM states, default
// geometry, RGB565 colour-bar table and the RGB888 -> RGB565 conversion.
package pcie_pkg;

    localparam int LINE_PIX_DEF   = 1920;
    localparam int FIFO_DEPTH_DEF = 2048;

    typedef enum logic [1:0] {
        S_WAIT_SOF = 2'd0,
        S_ACTIVE   = 2'd1,
        S_DROP     = 2'd2
    } feed_state_t;

    // Colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [15:0] BAR_RGB565 [0:7] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        return BAR_RGB565[idx];
    endfunction

    // Truncating conversion, no rounding
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

endpackage

// File: rtl/pcie_pixel_feeder_if.sv
// Pixel-stream and pull-side signals of the PCIe pixel feeder.
// master = pixel source / line writer side, slave = the feeder itself.
interface pcie_pixel_feeder_if #(
    parameter int AW = 11
);
    logic          pix_vld;
    logic          pix_sof;
    logic          pix_eol;
    logic [23:0]   pix_data;
    logic          pull_en;
    logic [15:0]   pull_data;
    logic          line_rdy;
    logic [AW:0]   fifo_level;

    modport master (
        output pix_vld, pix_sof, pix_eol, pix_data, pull_en,
        input  pull_data, line_rdy, fifo_level
    );

    modport slave (
        input  pix_vld, pix_sof, pix_eol, pix_data, pull_en,
        output pull_data, line_rdy, fifo_level
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO. The head is read from RAM into a register,
// so a word written into an empty FIFO shows on head_data one cycle later.
// Push/pop must already be guarded by the caller (no push when full, no
// pop when empty). head_data reads 0 while the FIFO is empty.
module sync_fifo_fwft #(
    parameter int DW    = 16,
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [DW-1:0] head_q;
    logic [AW:0]   level_q;

    assign rd_ptr_next = rd_ptr + AW'(pop);

    // RAM write port, no reset on the storage array
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head read
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr_next;
            head_q <= mem[rd_ptr_next];
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign head_data = (level_q != '0) ? head_q : '0;
    assign level     = level_q;

endmodule

// File: rtl/pcie_pixel_feeder.sv
// PCIe pixel feeder: RGB888 stream -> RGB565 FWFT buffer with line-ready
// tracking and sticky overflow/underflow flags.
// Optional build macro PCIE_FEEDER_TESTPAT_EN adds tp_sel and an internal
// 8-bar colour generator that replaces the pixel input while tp_sel=1.
module pcie_pixel_feeder
    import pcie_pkg::*;
#(
    parameter int LINE_PIX   = LINE_PIX_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AW         = 11
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic err_clr,
    output logic ovf_err,
    output logic udf_err,
`ifdef PCIE_FEEDER_TESTPAT_EN
    input  logic tp_sel,
`endif
    pcie_pixel_feeder_if.slave bus
);

    localparam int PCNT_W = $clog2(LINE_PIX);

    feed_state_t       state_q;
    feed_state_t       state_d;
    logic [AW:0]       level;
    logic [15:0]       head_data;
    logic              pop;
    logic              room;
    logic              pix_vld_eff;
    logic              pix_push;
    logic              ovf_set;
    logic              udf_set;
    logic              push;
    logic [15:0]       push_data;
    logic              push_eol;
    logic [PCNT_W-1:0] pull_cnt;
    logic              pull_wrap;
    logic              line_inc;
    logic [AW:0]       lines_buf;

    assign pop     = bus.pull_en && (level != '0);
    assign room    = (level != (AW+1)'(FIFO_DEPTH)) || pop;
    assign udf_set = bus.pull_en && (level == '0);

`ifdef PCIE_FEEDER_TESTPAT_EN
    localparam int BAR_W = LINE_PIX / 8;

    logic [PCNT_W-1:0] tp_cnt;
    logic [PCNT_W-1:0] tp_bar_cnt;
    logic [2:0]        tp_bar;
    logic              tp_push;
    logic              tp_eol;

    assign pix_vld_eff = bus.pix_vld && !tp_sel;
    assign tp_push     = tp_sel && room;
    assign tp_eol      = (tp_cnt == PCNT_W'(LINE_PIX - 1));

    // Colour-bar position: pixel within line, pixel within bar, bar index
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tp_cnt     <= '0;
            tp_bar_cnt <= '0;
            tp_bar     <= '0;
        end else if (tp_push) begin
            if (tp_eol) begin
                tp_cnt     <= '0;
                tp_bar_cnt <= '0;
                tp_bar     <= '0;
            end else begin
                tp_cnt <= tp_cnt + 1'b1;
                if (tp_bar_cnt == PCNT_W'(BAR_W - 1)) begin
                    tp_bar_cnt <= '0;
                    tp_bar     <= tp_bar + 1'b1;
                end else begin
                    tp_bar_cnt <= tp_bar_cnt + 1'b1;
                end
            end
        end
    end

    assign push      = tp_sel ? tp_push : pix_push;
    assign push_data = tp_sel ? bar_colour(tp_bar) : rgb888_to_565(bus.pix_data);
    assign push_eol  = tp_sel ? tp_eol : bus.pix_eol;
`else
    assign pix_vld_eff = bus.pix_vld;
    assign push        = pix_push;
    assign push_data   = rgb888_to_565(bus.pix_data);
    assign push_eol    = bus.pix_eol;
`endif

    // Input FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Input FSM: decide push, then turn a refused push into overflow/drop
    always_comb begin
        state_d  = state_q;
        pix_push = 1'b0;
        ovf_set  = 1'b0;
        case (state_q)
            S_WAIT_SOF: begin
                if (pix_vld_eff && bus.pix_sof) begin
                    pix_push = 1'b1;
                    state_d  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (pix_vld_eff) begin
                    pix_push = 1'b1;
                end
            end
            S_DROP: begin
                if (pix_vld_eff) begin
                    if (bus.pix_sof) begin
                        pix_push = 1'b1;
                        state_d  = S_ACTIVE;
                    end else if (bus.pix_eol) begin
                        state_d = S_ACTIVE;
                    end
                end
            end
            default: state_d = S_WAIT_SOF;
        endcase
        if (pix_push && !room) begin
            pix_push = 1'b0;
            ovf_set  = 1'b1;
            state_d  = bus.pix_eol ? S_ACTIVE : S_DROP;
        end
    end

    sync_fifo_fwft #(
        .DW    (16),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .level     (level)
    );

    assign pull_wrap = bus.pull_en && (pull_cnt == PCNT_W'(LINE_PIX - 1));
    assign line_inc  = push && push_eol;

    // Pull-side pixel counter; advances on every pull_en, even when empty
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pull_cnt <= '0;
        end else if (bus.pull_en) begin
            pull_cnt <= pull_wrap ? '0 : pull_cnt + 1'b1;
        end
    end

    // Buffered-line count; a simultaneous eol push and line wrap cancel out
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lines_buf <= '0;
        end else if (line_inc && !pull_wrap) begin
            lines_buf <= lines_buf + 1'b1;
        end else if (!line_inc && pull_wrap && (lines_buf != '0)) begin
            lines_buf <= lines_buf - 1'b1;
        end
    end

    // Sticky error flags; a new error beats a same-cycle clear
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_set || (ovf_err && !err_clr);
            udf_err <= udf_set || (udf_err && !err_clr);
        end
    end

    assign bus.pull_data  = head_data;
    assign bus.fifo_level = level;
    assign bus.line_rdy   = (lines_buf != '0);

endmodule

// File: tb/tb_pcie_pixel_feeder.sv
// Directed self-checking bench for pcie_pixel_feeder.
// Covers the PCIE_FEEDER_TESTPAT_EN generator when that macro is defined.
module tb_pcie_pixel_feeder;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic err_clr   = 1'b0;
    logic ovf_err;
    logic udf_err;
`ifdef PCIE_FEEDER_TESTPAT_EN
    logic tp_sel = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    pcie_pixel_feeder_if #(.AW(11)) bus();

    pcie_pixel_feeder #(
        .LINE_PIX   (1920),
        .FIFO_DEPTH (2048),
        .AW         (11)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .err_clr   (err_clr),
        .ovf_err   (ovf_err),
        .udf_err   (udf_err),
`ifdef PCIE_FEEDER_TESTPAT_EN
        .tp_sel    (tp_sel),
`endif
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Pixel i chosen so its RGB565 form is unique for any 11-bit index
    function automatic logic [23:0] pix_of(input int i);
        logic [10:0] v;
        logic [4:0]  b;
        v = 11'(i);
        b = 5'(i * 3);
        return {v[4:0], 3'b101, v[10:5], 2'b10, b, 3'b011};
    endfunction

    function automatic logic [15:0] exp_of(input int i);
        logic [10:0] v;
        logic [4:0]  b;
        v = 11'(i);
        b = 5'(i * 3);
        return {v[4:0], v[10:5], b};
    endfunction

    // Drive one cycle of inputs, return 1 time unit after the consuming edge
    task automatic applyStimulus(input logic vld, input logic sof, input logic eol,
                                 input logic [23:0] data, input logic pull, input logic clr);
        bus.pix_vld  = vld;
        bus.pix_sof  = sof;
        bus.pix_eol  = eol;
        bus.pix_data = data;
        bus.pull_en  = pull;
        err_clr      = clr;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        bus.pix_vld  = 1'b0;
        bus.pix_sof  = 1'b0;
        bus.pix_eol  = 1'b0;
        bus.pix_data = '0;
        bus.pull_en  = 1'b0;
        err_clr      = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

`ifdef PCIE_FEEDER_TESTPAT_EN
    logic [15:0] bars [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

    initial begin
        $display("[TB] start");
        doReset();

        // Reset values
        checkOutput("rst_pull_data", 32'(bus.pull_data), 32'h0);
        checkOutput("rst_line_rdy", 32'(bus.line_rdy), 32'h0);
        checkOutput("rst_level", 32'(bus.fifo_level), 32'h0);
        checkOutput("rst_ovf", 32'(ovf_err), 32'h0);
        checkOutput("rst_udf", 32'(udf_err), 32'h0);

        // Pixels without any sof are discarded
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, i == 4, pix_of(i), 1'b0, 1'b0);
        checkOutput("nosof_level", 32'(bus.fifo_level), 32'h0);
        checkOutput("nosof_ovf", 32'(ovf_err), 32'h0);
        checkOutput("nosof_udf", 32'(udf_err), 32'h0);
        checkOutput("nosof_rdy", 32'(bus.line_rdy), 32'h0);

        // One full line in, then pulled back-to-back
        for (int i = 0; i < 1920; i++) begin
            applyStimulus(1'b1, i == 0, i == 1919, (i == 0) ? 24'hFF8040 : pix_of(i), 1'b0, 1'b0);
            if (i == 1918) checkOutput("rdy_before_eol", 32'(bus.line_rdy), 32'h0);
        end
        checkOutput("rdy_after_eol", 32'(bus.line_rdy), 32'h1);
        checkOutput("line1_level", 32'(bus.fifo_level), 32'd1920);
        for (int i = 0; i < 1920; i++) begin
            checkOutput("line1_data", 32'(bus.pull_data), (i == 0) ? 32'hFC08 : 32'(exp_of(i)));
            if (i == 1919) checkOutput("rdy_before_last_pull", 32'(bus.line_rdy), 32'h1);
            applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        end
        checkOutput("rdy_after_pulls", 32'(bus.line_rdy), 32'h0);
        checkOutput("level_after_pulls", 32'(bus.fifo_level), 32'h0);

        // Reset mid-line returns to waiting for sof
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, i == 0, 1'b0, pix_of(i), 1'b0, 1'b0);
        checkOutput("midline_level", 32'(bus.fifo_level), 32'd5);
        doReset();
        checkOutput("midrst_level", 32'(bus.fifo_level), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, pix_of(i), 1'b0, 1'b0);
        checkOutput("midrst_nosof_level", 32'(bus.fifo_level), 32'h0);

        // Eol push of line B in the same cycle as the last pull of line A
        doReset();
        for (int i = 0; i < 1920; i++) applyStimulus(1'b1, i == 0, i == 1919, pix_of(i), 1'b0, 1'b0);
        for (int i = 0; i < 1920; i++) begin
            checkOutput("lineA_data", 32'(bus.pull_data), 32'(exp_of(i)));
            applyStimulus(1'b1, 1'b0, i == 1919, pix_of(i + 1000), 1'b1, 1'b0);
        end
        checkOutput("same_cycle_rdy", 32'(bus.line_rdy), 32'h1);
        checkOutput("same_cycle_level", 32'(bus.fifo_level), 32'd1920);
        for (int i = 0; i < 1920; i++) begin
            checkOutput("lineB_data", 32'(bus.pull_data), 32'(exp_of(i + 1000)));
            applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        end
        checkOutput("lineB_rdy_drop", 32'(bus.line_rdy), 32'h0);

        // Overflow: 2100-pixel line with no pulls
        doReset();
        for (int i = 0; i < 2100; i++) begin
            applyStimulus(1'b1, i == 0, i == 2099, pix_of(i), 1'b0, 1'b0);
            if (i == 2047) begin
                checkOutput("full_no_ovf", 32'(ovf_err), 32'h0);
                checkOutput("full_level", 32'(bus.fifo_level), 32'd2048);
            end
            if (i == 2048) checkOutput("ovf_set", 32'(ovf_err), 32'h1);
        end
        checkOutput("ovf_level", 32'(bus.fifo_level), 32'd2048);
        checkOutput("ovf_sticky", 32'(ovf_err), 32'h1);
        checkOutput("ovf_rdy", 32'(bus.line_rdy), 32'h0);
        for (int i = 0; i < 100; i++) begin
            checkOutput("ovf_data", 32'(bus.pull_data), 32'(exp_of(i)));
            applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        end
        for (int j = 0; j < 10; j++) applyStimulus(1'b1, 1'b0, j == 9, (j == 0) ? 24'h123456 : pix_of(j + 500), 1'b0, 1'b0);
        checkOutput("newline_level", 32'(bus.fifo_level), 32'd1958);
        checkOutput("newline_rdy", 32'(bus.line_rdy), 32'h1);
        for (int i = 100; i < 2048; i++) begin
            checkOutput("ovf_keep_data", 32'(bus.pull_data), 32'(exp_of(i)));
            applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        end
        checkOutput("newline_head", 32'(bus.pull_data), 32'h11AA);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        checkOutput("ovf_clr", 32'(ovf_err), 32'h0);

        // Underflow and clear priority
        doReset();
        bus.pull_en = 1'b1;
        #1;
        checkOutput("udf_pull_data", 32'(bus.pull_data), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        checkOutput("udf_set", 32'(udf_err), 32'h1);
        checkOutput("udf_level", 32'(bus.fifo_level), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
        checkOutput("udf_set_beats_clr", 32'(udf_err), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        checkOutput("udf_clr", 32'(udf_err), 32'h0);
        checkOutput("udf_no_ovf", 32'(ovf_err), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 24'hFF8040, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("udf_ptr_kept_data", 32'(bus.pull_data), 32'hFC08);
        checkOutput("udf_ptr_kept_level", 32'(bus.fifo_level), 32'h1);

`ifdef PCIE_FEEDER_TESTPAT_EN
        // Colour-bar generator
        doReset();
        tp_sel = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
        for (int i = 0; i < 1920; i++) begin
            checkOutput("tp_bar", 32'(bus.pull_data), 32'(bars[i / 240]));
            applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        end
        tp_sel = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
